// File: rtl/mips_mc_control_pkg.sv
// rtl/mips_mc_control_pkg.sv - shared types and encodings for the multi-cycle MIPS control FSM
package mips_ctrl_pkg;

    // The encoding values appear on the debug state port, so they must stay fixed.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_FAULT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] SRC_B_REG      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR     = 2'b01;
    localparam logic [1:0] SRC_B_IMM      = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // States that own the memory port and therefore wait on mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// rtl/mips_mc_control_if.sv - control bus between the FSM (master) and the shared datapath (slave)
// Datapath status : opcode (IR[31:26]), zero (ALU flag), mem_ready (memory access done)
// Control outputs : pc_we, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg, reg_we,
//                   alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0]
interface mips_mc_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_we;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_we, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg, reg_we,
               alu_src_a, alu_src_b, alu_op, pc_src
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_we, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg, reg_we,
               alu_src_a, alu_src_b, alu_op, pc_src
    );
endinterface

// File: rtl/mips_mc_control_wait_timer.sv
// rtl/mips_mc_control_wait_timer.sv - memory wait-state counter with timeout compare
// clk, rst_n : clock, asynchronous active-low reset
// start      : state is changing this cycle; counter restarts from 0 for the next state
// ready      : memory completes the access this cycle
// enable     : current state is a memory state
// expired    : limit reached with the access still outstanding
module mips_mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic ready,
    input  logic enable,
    output logic expired
);
    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

    logic [7:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (start) begin
            wait_cnt <= 8'd0;
        end else if (enable && !ready && (wait_cnt != 8'hFF)) begin
            // Saturate so a disabled timeout cannot wrap back into a false match.
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // A ready on the limit cycle wins: it is a completion, not a timeout.
    assign expired = (MEM_TIMEOUT != 0) && enable && !ready && (wait_cnt == LIMIT);

endmodule

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multi-cycle MIPS main control FSM with memory wait/timeout and retire counter
// clk, rst_n  : clock, asynchronous active-low reset
// bus         : mips_mc_control_if.master (opcode/zero/mem_ready in, datapath controls out)
// fault       : sticky fault code (00 none, 01 illegal opcode, 10 bus timeout)
// instr_count : retired instructions, wraps
// state       : current state encoding
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_mc_control_if.master   bus,
    output logic [1:0]          fault,
    output logic [CNT_W-1:0]    instr_count,
    output logic [3:0]          state
);
    state_t             state_q, next_state;
    logic [1:0]         fault_q, fault_set;
    logic [CNT_W-1:0]   count_q;
    logic               retire;
    logic               timer_start, timer_enable, timer_expired;

    logic       pc_we, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg, reg_we, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;

    assign timer_enable = is_mem_state(state_q);
    assign timer_start  = (next_state != state_q);

    mips_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (timer_start),
        .ready   (bus.mem_ready),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Outputs are gated by rst_n so that asserting reset kills every strobe
    // immediately, without waiting for the asynchronous state reset to settle.
    always_comb begin
        next_state = state_q;
        fault_set  = FAULT_NONE;
        retire     = 1'b0;
        pc_we      = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_we      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_we     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_REG;
        alu_op     = ALU_ADD;
        pc_src     = PC_SRC_ALU;

        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_rd    = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    ir_we     = bus.mem_ready;
                    pc_we     = bus.mem_ready;
                    if (bus.mem_ready) begin
                        next_state = S_DECODE;
                    end else if (timer_expired) begin
                        next_state = S_FAULT;
                        fault_set  = FAULT_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    // Branch target computed speculatively into ALUOut.
                    alu_src_b = SRC_B_IMM_SHL2;
                    case (bus.opcode)
                        OP_RTYPE:     next_state = S_R_EXEC;
                        OP_LW, OP_SW: next_state = S_MEM_ADDR;
                        OP_BEQ:       next_state = S_BRANCH;
                        OP_J:         next_state = S_JUMP;
                        OP_ADDI:      next_state = S_ADDI_EXEC;
                        default: begin
                            next_state = S_FAULT;
                            fault_set  = FAULT_ILLEGAL;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRC_B_IMM;
                    next_state = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    mem_rd = 1'b1;
                    iord   = 1'b1;
                    if (bus.mem_ready) begin
                        next_state = S_MEM_WB;
                    end else if (timer_expired) begin
                        next_state = S_FAULT;
                        fault_set  = FAULT_TIMEOUT;
                    end
                end
                S_MEM_WB: begin
                    reg_we     = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_wr = 1'b1;
                    iord   = 1'b1;
                    if (bus.mem_ready) begin
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end else if (timer_expired) begin
                        next_state = S_FAULT;
                        fault_set  = FAULT_TIMEOUT;
                    end
                end
                S_R_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_FUNCT;
                    next_state = S_R_WB;
                end
                S_R_WB: begin
                    reg_we     = 1'b1;
                    reg_dst    = 1'b1;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_SUB;
                    pc_src     = PC_SRC_ALUOUT;
                    pc_we      = bus.zero;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
                S_JUMP: begin
                    pc_src     = PC_SRC_JUMP;
                    pc_we      = 1'b1;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
                S_ADDI_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRC_B_IMM;
                    next_state = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    reg_we     = 1'b1;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
                default: begin
                    // S_FAULT and unused encodings park here until reset.
                    next_state = S_FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            fault_q <= FAULT_NONE;
            count_q <= '0;
        end else begin
            state_q <= next_state;
            if ((fault_q == FAULT_NONE) && (fault_set != FAULT_NONE)) begin
                fault_q <= fault_set;
            end
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_we      = pc_we;
    assign bus.iord       = iord;
    assign bus.mem_rd     = mem_rd;
    assign bus.mem_wr     = mem_wr;
    assign bus.ir_we      = ir_we;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_we     = reg_we;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.pc_src     = pc_src;

    assign fault       = fault_q;
    assign instr_count = count_q;
    assign state       = state_q;

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle MIPS main control FSM that sequences the shared datapath: PC, IR, register file, single ALU and a unified instruction/data memory.
- Selects ALU operands, including the sign-extended, left-shifted-by-2 branch offset used for the branch target.
- Supports R-type, lw, sw, beq, j and addi.
- Adds a memory ready/wait handshake with timeout, a sticky fault code and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 15, max wait cycles (1..255) for mem_ready in any memory state; 0 disables the timeout.
- CNT_W, 32, width of instr_count.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_we  out  1  PC write enable, final (branch already resolved)
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- ir_we  out  1  IR write enable
- reg_dst  out  1  write register: 0=rt, 1=rd
- mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
- reg_we  out  1  register-file write enable
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm shifted left 2
- alu_op  out  2  00=add, 01=sub, 10=use funct
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- fault  out  2  00=none, 01=illegal opcode, 10=bus timeout (sticky)
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
- state  out  4  current state encoding, for debug

Behaviour:
- Reset: rst_n low forces state=FETCH, fault=00, instr_count=0 and the wait counter to 0. While rst_n=0, every strobe (pc_we, ir_we, mem_rd, mem_wr, reg_we) is 0 and all selects are 0. The first active edge after release executes FETCH.
- Reset mid-instruction abandons the instruction; no partial write completes after rst_n falls.
- Moore decode from state, except ir_we/pc_we in FETCH (gated by mem_ready) and pc_we in BRANCH (gated by zero).
- States (encoding) and actions:
  - FETCH(0): mem_rd=1, iord=0, a=0, b=01, op=00, pc_src=00, ir_we=pc_we=mem_ready. Holds until mem_ready, then DECODE.
  - DECODE(1): a=0, b=11, op=00 (branch target into ALUOut). Next state by opcode: 000000→R_EXEC, 100011/101011→MEM_ADDR, 000100→BRANCH, 000010→JUMP, 001000→ADDI_EXEC, other→FAULT with fault=01.
  - MEM_ADDR(2): a=1, b=10, op=00. Next is MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ(3): mem_rd=1, iord=1. On mem_ready → MEM_WB.
  - MEM_WB(4): reg_we=1, reg_dst=0, mem_to_reg=1. Retires; next FETCH.
  - MEM_WRITE(5): mem_wr=1, iord=1. On mem_ready, retires; next FETCH.
  - R_EXEC(6): a=1, b=00, op=10. Next R_WB.
  - R_WB(7): reg_we=1, reg_dst=1, mem_to_reg=0. Retires; next FETCH.
  - BRANCH(8): a=1, b=00, op=01, pc_src=01, pc_we=zero. Retires; next FETCH.
  - JUMP(9): pc_src=10, pc_we=1. Retires; next FETCH.
  - ADDI_EXEC(10): a=1, b=10, op=00. Next ADDI_WB.
  - ADDI_WB(11): reg_we=1, reg_dst=0, mem_to_reg=0. Retires; next FETCH.
  - FAULT(15): all strobes 0. Terminal until reset.
- Memory states are FETCH, MEM_READ and MEM_WRITE. Strobes stay asserted and stable while waiting.
- Wait counter: cleared on entry to each memory state and incremented each cycle mem_ready=0. If MEM_TIMEOUT≠0 and counter==MEM_TIMEOUT with mem_ready still 0, next state is FAULT with fault=10.
- mem_ready=1 on the same cycle the counter reaches MEM_TIMEOUT counts as completion, not a timeout.
- mem_ready is ignored outside memory states.
- instr_count increments by 1 on the clock edge that leaves a retiring state. Cycles per instruction with zero wait states: lw=5, sw/R/addi=4, beq/j=3.
- fault is written only once; its first non-zero value sticks.

Decomposition:
- Package mips_ctrl_pkg holds the state enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), alu_src_b/alu_op/pc_src encodings and fault codes.
- One sub-module, mips_mem_wait_timer: wait counter plus timeout compare, with inputs start/ready/enable and output expired.

Test Plan:
- lw (0x23), mem_ready=1 always → states 0,1,2,3,4,0. reg_we=1 and mem_to_reg=1 only in state 4. instr_count 0→1 after 5 cycles.
- beq (0x04): zero=1 → pc_we=1 with pc_src=01 in BRANCH. zero=0 → pc_we=0. Both take 3 cycles.
- sw with mem_ready low 3 cycles in MEM_WRITE → mem_wr held for 4 cycles and iord=1 throughout. Retires with no fault.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH → FAULT after 5 cycles, fault=10, ir_we never asserted. Stays in FAULT until rst_n pulse.
- opcode 0x3F in DECODE → fault=01, state=15, no further strobes. Back-to-back R_EXEC/ADDI sequences before this count correctly.
- rst_n dropped asynchronously mid-MEM_WB → reg_we falls immediately (no edge needed), instr_count=0. Restart at FETCH on the first edge after release.
